// File: rtl/serial_adder_ctrl_if.sv
// Operand and result handshake bundle for serial_adder_ctrl.
// The master side supplies operands and consumes results; the slave side is the sequencer.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: drives one external 1-bit full adder LSB first,
// one bit per clock, and returns sum, carry and signed overflow over a valid/ready handshake.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_adder_ctrl_if.slave   bus,
  output logic                 fa_a,
  output logic                 fa_b,
  output logic                 fa_cin,
  input  logic                 fa_s,
  input  logic                 fa_cout,
  output logic                 busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_cout;
  logic             r_out_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_in_ready;
  logic             w_out_valid;
  logic [WIDTH-1:0] w_sum_next;

  // Incoming sum bit enters at the MSB so after WIDTH shifts bit 0 lands at the LSB.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign w_sum_next = fa_s;
    end else begin : g_sum_wn
      assign w_sum_next = {fa_s, r_sum_sh[WIDTH-1:1]};
    end
  endgenerate

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    fa_a        = 1'b0;
    fa_b        = 1'b0;
    fa_cin      = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        busy   = 1'b1;
        fa_a   = r_a_sh[0];
        fa_b   = r_b_sh[0];
        fa_cin = r_carry;
        if (r_cnt == LAST_BIT) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_sum_sh   <= '0;
      r_carry    <= 1'b0;
      r_out_sum  <= '0;
      r_out_cout <= 1'b0;
      r_out_ovf  <= 1'b0;
    end else if (w_accept) begin
      // Subtract is A + ~B + 1: invert B once here and force the initial carry.
      r_a_sh  <= bus.in_a;
      r_b_sh  <= bus.in_sub ? ~bus.in_b : bus.in_b;
      r_carry <= bus.in_sub | bus.in_cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_sum_sh <= w_sum_next;
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_carry  <= fa_cout;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        // Carry into the MSB is fa_cin on this cycle; XOR with carry out flags signed overflow.
        r_out_sum  <= w_sum_next;
        r_out_cout <= fa_cout;
        r_out_ovf  <= fa_cin ^ fa_cout;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_cout  = r_out_cout;
  assign bus.out_ovf   = r_out_ovf;

  a_done_hold: assert property (@(posedge clk) disable iff (rst)
    (r_state == S_DONE && !bus.out_ready) |=> (r_state == S_DONE && $stable(r_out_sum)));

  a_no_overlap: assert property (@(posedge clk) disable iff (rst)
    (r_state != S_IDLE) |-> !w_in_ready);

endmodule
